// File: rtl/bch_enc_ser.sv
// Bit-serial systematic BCH encoder: forwards information bits MSB first and
// appends r = deg g(x) parity bits produced by LFSR division by g(x).
module bch_enc_ser #(
  parameter int m      = 4,
  parameter int k_max  = 5,
  parameter int d      = 7,
  parameter int n      = 15,
  parameter int irrpol = 19
) (
  input  logic iclk,
  input  logic ireset,
  input  logic iclkena,
  input  logic isop,
  input  logic ival,
  input  logic ieop,
  input  logic idat,
  output logic ordy,
  output logic osop,
  output logic oval,
  output logic oeop,
  output logic odat,
  output logic oerr
);

  localparam int unsigned MAXN = 256;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sh;
    logic [7:0] p;
    sh = {1'b0, a};
    p  = '0;
    for (int unsigned i = 0; i < m; i++) begin
      if (b[3'(i)]) p = p ^ sh[7:0];
      sh = sh << 1;
      if (sh[4'(m)]) sh = sh ^ 9'(irrpol);
    end
    return p;
  endfunction

  // Exponents e whose alpha^e is a root of g: union of the cyclotomic
  // cosets of 1 .. d-1.
  function automatic logic [MAXN-1:0] calc_roots();
    logic [MAXN-1:0] rs;
    int unsigned     e;
    rs = '0;
    for (int unsigned i = 1; i < d; i++) begin
      e = i % n;
      for (int unsigned j = 0; j < m; j++) begin
        rs[8'(e)] = 1'b1;
        e = (2 * e) % n;
      end
    end
    return rs;
  endfunction

  localparam logic [MAXN-1:0] ROOTS = calc_roots();
  localparam int              R     = $countones(ROOTS);

  // g(x) = product of (x + alpha^e) over the root set; the coefficients are
  // carried in GF(2^m) and collapse to 0/1 once every coset is multiplied in.
  function automatic logic [MAXN-1:0] calc_g();
    logic [8*MAXN-1:0] c;
    logic [MAXN-1:0]   gv;
    logic [7:0]        a;
    logic [7:0]        lo;
    logic [7:0]        cur;
    int unsigned       deg;
    c      = '0;
    c[7:0] = 8'd1;
    deg    = 0;
    a      = 8'd1;
    for (int unsigned e = 0; e < n; e++) begin
      if (ROOTS[8'(e)]) begin
        lo = '0;
        for (int unsigned j = 0; j <= deg + 1; j++) begin
          cur = c[11'(8 * j) +: 8];
          c[11'(8 * j) +: 8] = lo ^ gf_mul(cur, a);
          lo = cur;
        end
        deg++;
      end
      a = gf_mul(a, 8'd2);
    end
    gv = '0;
    for (int unsigned j = 0; j <= n; j++) gv[8'(j)] = c[11'(8 * j)];
    return gv;
  endfunction

  localparam logic [MAXN-1:0] G_FULL = calc_g();
  localparam logic [R-1:0]    G      = G_FULL[R-1:0];
  localparam int              CW     = $clog2(k_max + 1);
  localparam int              PW     = $clog2(R + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t        state, state_nxt;
  logic [R-1:0]  lfsr, lfsr_nxt, lfsr_base;
  logic [CW-1:0] cnt, cnt_nxt, cnt_base;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          osop_nxt, oval_nxt, oeop_nxt, odat_nxt, oerr_nxt;
  logic          acc, fb;

  assign ordy = (state != PARITY);
  assign acc  = iclkena & ival & ordy;

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;
    pcnt_nxt  = pcnt;
    osop_nxt  = 1'b0;
    oval_nxt  = 1'b0;
    oeop_nxt  = 1'b0;
    odat_nxt  = 1'b0;
    oerr_nxt  = 1'b0;
    // isop always opens a fresh frame, whether from IDLE or as a restart in DATA
    lfsr_base = isop ? '0 : lfsr;
    cnt_base  = isop ? '0 : cnt;
    fb        = idat ^ lfsr_base[R-1];
    case (state)
      IDLE, DATA: begin
        if (acc) begin
          if (isop || state == DATA) begin
            lfsr_nxt = (lfsr_base << 1) ^ (fb ? G : '0);
            cnt_nxt  = cnt_base + 1'b1;
            oval_nxt = 1'b1;
            odat_nxt = idat;
            osop_nxt = isop;
            oerr_nxt = isop && (state == DATA);
            if (ieop || cnt_base == CW'(k_max - 1)) begin
              state_nxt = PARITY;
              pcnt_nxt  = '0;
              if (!ieop) oerr_nxt = 1'b1;
            end else begin
              state_nxt = DATA;
            end
          end else begin
            oerr_nxt = 1'b1;
          end
        end
      end
      PARITY: begin
        oval_nxt = 1'b1;
        odat_nxt = lfsr[R-1];
        lfsr_nxt = lfsr << 1;
        pcnt_nxt = pcnt + 1'b1;
        if (pcnt == PW'(R - 1)) begin
          oeop_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state <= IDLE;
      lfsr  <= '0;
      cnt   <= '0;
      pcnt  <= '0;
      osop  <= 1'b0;
      oval  <= 1'b0;
      oeop  <= 1'b0;
      odat  <= 1'b0;
      oerr  <= 1'b0;
    end else if (iclkena) begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      cnt   <= cnt_nxt;
      pcnt  <= pcnt_nxt;
      osop  <= osop_nxt;
      oval  <= oval_nxt;
      oeop  <= oeop_nxt;
      odat  <= odat_nxt;
      oerr  <= oerr_nxt;
    end
  end

endmodule

// File: tb/tb_bch_enc_ser.sv
// Self-checking bench for bch_enc_ser: fixed codeword table, hand-built
// framing corner cases and random frames against a polynomial-division model.
module tb_bch_enc_ser;

  localparam int          R     = 10;
  localparam int          KMAX  = 5;
  localparam logic [63:0] GPOLY = 64'h537;

  logic clk = 1'b0;
  logic ireset, iclkena, isop, ival, ieop, idat;
  logic ordy, osop, oval, oeop, odat, oerr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {logic sop, val, eop, dat, err, rdy;} rec_t;
  typedef struct {int len; logic [31:0] bits; logic [31:0] parity;} vec_t;

  rec_t got[$];
  rec_t exp_q[$];
  logic en_q  = 1'b0;
  bit   mon_on = 1'b0;

  bch_enc_ser #(.m(4), .k_max(5), .d(7), .n(15), .irrpol(19)) dut (
    .iclk(clk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ival(ival),
    .ieop(ieop), .idat(idat), .ordy(ordy), .osop(osop), .oval(oval),
    .oeop(oeop), .odat(odat), .oerr(oerr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) en_q <= iclkena;
  // one record per enabled cycle, taken half a period after the edge
  always @(negedge clk)
    if (mon_on && en_q) got.push_back(rec_t'({osop, oval, oeop, odat, oerr, ordy}));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got_v, exp_v);
    end
  endtask

  function automatic rec_t mk(input logic s, input logic v, input logic e, input logic dd, input logic er);
    return rec_t'({s, v, e, dd, er, 1'b0});
  endfunction

  // parity = msg(x) * x^R mod g(x), by long division
  function automatic logic [31:0] ref_parity(input logic [31:0] msg, input int len);
    logic [63:0] v;
    v = 64'(msg) << R;
    for (int dg = len + R - 1; dg >= R; dg--)
      if (v[dg]) v = v ^ (GPOLY << (dg - R));
    return v[31:0] & ((32'd1 << R) - 32'd1);
  endfunction

  task automatic exp_frame(input logic [31:0] msg, input int len, input bit err_first, input bit err_last);
    logic [31:0] p;
    for (int i = 0; i < len; i++)
      exp_q.push_back(mk(i == 0, 1'b1, 1'b0, msg[len-1-i],
                         (i == 0 && err_first) || (i == len - 1 && err_last)));
    p = ref_parity(msg, len);
    for (int j = 0; j < R; j++)
      exp_q.push_back(mk(1'b0, 1'b1, j == R - 1, p[R-1-j], 1'b0));
  endtask

  function automatic int count_val();
    int c = 0;
    foreach (got[i]) if (got[i].val || got[i].err) c++;
    return c;
  endfunction

  function automatic int first_val();
    foreach (got[i]) if (got[i].val) return i;
    return got.size();
  endfunction

  task automatic start_test();
    got.delete();
    exp_q.delete();
    mon_on = 1'b1;
  endtask

  task automatic put_bit(input logic b, input logic sop, input logic eop, input int en_pct);
    bit taken = 1'b0;
    ival = 1'b1; idat = b; isop = sop; ieop = eop;
    for (int t = 0; t < 200 && !taken; t++) begin
      iclkena = ($urandom_range(99) < en_pct);
      taken = iclkena && ordy;
      @(posedge clk); #1;
    end
    if (!taken) begin
      n_cmp++; n_err++;
      $display("FAIL put_bit: input not accepted within 200 cycles");
    end
  endtask

  task automatic send_frame(input logic [31:0] msg, input int len, input bit sop, input bit eop, input int en_pct);
    for (int i = 0; i < len; i++)
      put_bit(msg[len-1-i], sop && i == 0, eop && i == len - 1, en_pct);
  endtask

  task automatic idle_cycles(input int cyc, input int en_pct);
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 1'b0;
    repeat (cyc) begin
      iclkena = ($urandom_range(99) < en_pct);
      @(posedge clk); #1;
    end
  endtask

  task automatic settle(input int exp_cnt, input int en_pct);
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 1'b0;
    for (int t = 0; t < 1000 && count_val() < exp_cnt; t++) begin
      iclkena = ($urandom_range(99) < en_pct);
      @(posedge clk); #1;
    end
    idle_cycles(3, 100);
  endtask

  task automatic compare_stream(input string name);
    rec_t f[$];
    int   bad_idle = 0;
    foreach (got[i]) begin
      if (got[i].val || got[i].err) f.push_back(got[i]);
      if (!got[i].val && got[i].dat) bad_idle++;
    end
    check({name, " length"}, f.size(), exp_q.size());
    check({name, " odat idle"}, bad_idle, 0);
    for (int i = 0; i < f.size() && i < exp_q.size(); i++)
      check($sformatf("%s rec%0d", name, i), f[i][5:1], exp_q[i][5:1]);
  endtask

  initial begin
    vec_t        tbl[5];
    rec_t        ref_run[$];
    int          nval, nsop, neop, nlow, nerr, fv, run;
    logic [31:0] cw, msg;
    bit          first_sop, last_eop;
    int          len, en;

    tbl[0] = '{5, 32'h00, 32'h000};
    tbl[1] = '{5, 32'h01, 32'h137};
    tbl[2] = '{5, 32'h1F, 32'h3FF};
    tbl[3] = '{3, 32'h01, 32'h137};
    tbl[4] = '{2, 32'h03, 32'h359};

    ireset = 1'b1; iclkena = 1'b1; isop = 1'b0; ival = 1'b0; ieop = 1'b0; idat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs {sop,val,eop,dat,err,rdy}", {osop, oval, oeop, odat, oerr, ordy}, 6'b000001);
    ireset = 1'b0;
    idle_cycles(2, 100);

    for (int v = 0; v < 5; v++) begin
      start_test();
      send_frame(tbl[v].bits, tbl[v].len, 1'b1, 1'b1, 100);
      settle(tbl[v].len + R, 100);
      nval = 0; nsop = 0; neop = 0; nlow = 0; nerr = 0; cw = '0;
      first_sop = 1'b0; last_eop = 1'b0;
      foreach (got[i]) begin
        if (got[i].val) begin
          if (nval == 0) first_sop = got[i].sop;
          cw = {cw[30:0], got[i].dat};
          last_eop = got[i].eop;
          nval++;
        end
        if (got[i].sop) nsop++;
        if (got[i].eop) neop++;
        if (!got[i].rdy) nlow++;
        if (got[i].err) nerr++;
      end
      check($sformatf("tbl%0d oval count", v), nval, tbl[v].len + R);
      check($sformatf("tbl%0d codeword", v), cw, (tbl[v].bits << R) | tbl[v].parity);
      check($sformatf("tbl%0d osop", v), {32'(nsop), 1'b0, first_sop}, {32'd1, 1'b0, 1'b1});
      check($sformatf("tbl%0d oeop", v), {32'(neop), 1'b0, last_eop}, {32'd1, 1'b0, 1'b1});
      check($sformatf("tbl%0d ordy low cycles", v), nlow, R);
      check($sformatf("tbl%0d oerr", v), nerr, 0);
    end

    // back-to-back frames, clock enable always on
    start_test();
    send_frame(32'h01, 5, 1'b1, 1'b1, 100);
    send_frame(32'h1F, 5, 1'b1, 1'b1, 100);
    settle(30, 100);
    exp_frame(32'h01, 5, 1'b0, 1'b0);
    exp_frame(32'h1F, 5, 1'b0, 1'b0);
    compare_stream("b2b");
    fv = first_val();
    run = 0;
    for (int i = fv; i < got.size() && got[i].val; i++) run++;
    check("b2b contiguous oval", run, 30);
    check("b2b osop follows oeop",
          (fv + 15 < got.size()) ? {got[fv+14].eop, got[fv+15].sop} : 2'b00, 2'b11);
    ref_run.delete();
    for (int i = fv; i < fv + 31 && i < got.size(); i++) ref_run.push_back(got[i]);

    // same stimulus with random clock enable must give the same enabled-cycle sequence
    start_test();
    send_frame(32'h01, 5, 1'b1, 1'b1, 50);
    send_frame(32'h1F, 5, 1'b1, 1'b1, 50);
    settle(30, 50);
    fv = first_val();
    check("gated length", (got.size() >= fv + 31) && (ref_run.size() == 31), 1);
    for (int i = 0; i < 31 && fv + i < got.size() && i < ref_run.size(); i++)
      check($sformatf("gated rec%0d", i), got[fv+i], ref_run[i]);

    // seven bits without ieop: forced end after k_max, leftovers dropped
    start_test();
    send_frame(32'b1011001, 7, 1'b1, 1'b0, 100);
    exp_frame(32'b10110, 5, 1'b0, 1'b1);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    settle(exp_q.size(), 100);
    compare_stream("forced end");

    // isop in mid-frame restarts encoding
    foreach (tbl[k]) begin
      if (k < 2) begin
        en = (k == 0) ? 100 : 60;
        start_test();
        send_frame(32'b101, 3, 1'b1, 1'b0, en);
        send_frame(32'b01101, 5, 1'b1, 1'b1, en);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        exp_frame(32'b01101, 5, 1'b1, 1'b0);
        settle(exp_q.size(), en);
        compare_stream($sformatf("restart en%0d", en));
      end
    end

    // reset in the middle of parity output
    start_test();
    send_frame(32'h01, 5, 1'b1, 1'b1, 100);
    idle_cycles(3, 100);
    check("pre-reset oval", oval, 1'b1);
    ireset = 1'b1;
    @(posedge clk); #1;
    check("mid-parity reset {val,rdy,sop,eop,err,dat}", {oval, ordy, osop, oeop, oerr, odat}, 6'b010000);
    ireset = 1'b0;
    start_test();
    idle_cycles(15, 100);
    check("no output after reset", count_val(), 0);
    start_test();
    send_frame(32'h01, 5, 1'b1, 1'b1, 100);
    exp_frame(32'h01, 5, 1'b0, 1'b0);
    settle(exp_q.size(), 100);
    compare_stream("post-reset");

    // random frames, random gaps and clock enable
    start_test();
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(KMAX, 1);
      msg = $urandom & ((32'd1 << len) - 32'd1);
      en  = ($urandom_range(1) == 1) ? 100 : 55;
      send_frame(msg, len, 1'b1, 1'b1, en);
      exp_frame(msg, len, 1'b0, 1'b0);
      if ($urandom_range(2) == 0) idle_cycles($urandom_range(3), en);
    end
    settle(exp_q.size(), 70);
    compare_stream("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
